proc_run_dump_ctrl: RTL and testbench

Run-control and result-dump engine for processor test harnesses. Sequences processor reset, watches the instruction fetch stream for end-of-program, stops the processor, then streams a configurable DMEM window word-by-word over a valid/ready port. Sits between the processor top, its DMEM read port, and a bench or debug consumer. Generalises fixed-program, fixed-window run/dump into a synthesizable, parametrised block with halt-instruction, watchdog and handshake support.

---
 rtl/proc_harness_pkg.sv | 31 +++
 rtl/run_watchdog.sv | 29 ++
 rtl/proc_run_dump_ctrl.sv | 148 ++++++++++++++
 tb/tb_proc_run_dump_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_harness_pkg.sv
// Shared types for the processor run/dump harness: FSM state encoding and
// halt cause codes, plus the halt-cause priority selector.
package proc_harness_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRERST   = 3'd1,
    ST_RUN      = 3'd2,
    ST_DUMP_REQ = 3'd3,
    ST_DUMP_OUT = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  localparam logic [1:0] HALT_NONE    = 2'b00;
  localparam logic [1:0] HALT_INSTR_C = 2'b01;
  localparam logic [1:0] HALT_XDET    = 2'b10;
  localparam logic [1:0] HALT_WDOG    = 2'b11;

  // Halt instruction wins over X detection, which wins over the watchdog.
  function automatic logic [1:0] halt_select(input logic instr_hit,
                                             input logic x_hit,
                                             input logic wdog_hit);
    logic [1:0] cause;
    cause = HALT_NONE;
    if (instr_hit)     cause = HALT_INSTR_C;
    else if (x_hit)    cause = HALT_XDET;
    else if (wdog_hit) cause = HALT_WDOG;
    return cause;
  endfunction

endpackage

// File: rtl/run_watchdog.sv
// RUN-cycle counter: cleared at run start, advances while enabled, flags when
// the count sits at MAX_CYCLES-1 (the last RUN cycle allowed).
module run_watchdog #(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned MAX_CYCLES = 100000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             limit
);

  localparam logic [CNT_W-1:0] LIMIT_VAL = CNT_W'(MAX_CYCLES - 1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign limit = (count == LIMIT_VAL);

endmodule

// File: rtl/proc_run_dump_ctrl.sv
// Run-control and DMEM dump engine: resets the processor, runs it until a halt
// instruction or watchdog expiry, then streams a DMEM window over valid/ready.
// Optional: define HALT_XDETECT_EN to halt on X/Z fetches (cause 10).
//
// Handshake: dump_valid rises with dump_data already stable; a word is
// transferred on any rising edge where dump_valid && dump_ready, and until
// then dump_valid, dump_data and dump_last hold.
module proc_run_dump_ctrl
  import proc_harness_pkg::*;
#(
  parameter int unsigned          ADDR_W       = 32,
  parameter int unsigned          DATA_W       = 32,
  parameter int unsigned          DUMP_BASE    = 8192,
  parameter int unsigned          DUMP_WORDS   = 46,
  parameter logic [DATA_W-1:0]    HALT_INSTR   = 32'hFFFF_FFFF,
  parameter int unsigned          MAX_CYCLES   = 100000,
  parameter int unsigned          RESET_CYCLES = 1,
  parameter int unsigned          CNT_W        = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] inst,
  input  logic              inst_valid,
  output logic              proc_reset,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic              dump_last,
  output logic              done,
  output logic [1:0]        halt_cause,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [2:0]        fsm_state
);

  localparam logic [31:0]       LAST_IDX    = 32'(DUMP_WORDS - 1);
  localparam logic [31:0]       RST_LAST    = 32'(RESET_CYCLES - 1);
  localparam logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(DUMP_BASE);
  localparam bit                NO_DUMP     = (DUMP_WORDS == 0);

  state_t      state;
  state_t      state_next;
  logic [31:0] rst_cnt;
  logic [31:0] idx;
  logic        start_ok;
  logic        instr_hit;
  logic        x_hit;
  logic        wdog_hit;
  logic        halt;
  logic        is_last;
  logic [1:0]  cause_sel;

  assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign instr_hit = inst_valid && (inst == HALT_INSTR);
`ifdef HALT_XDETECT_EN
  assign x_hit     = inst_valid && $isunknown(inst);
`else
  assign x_hit     = 1'b0;
`endif
  assign halt      = (state == ST_RUN) && (instr_hit || x_hit || wdog_hit);
  assign cause_sel = halt_select(instr_hit, x_hit, wdog_hit);
  assign is_last   = (idx == LAST_IDX);

  // The halting cycle itself is not counted, so the count freezes at c.
  run_watchdog #(
    .CNT_W      (CNT_W),
    .MAX_CYCLES (MAX_CYCLES)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (start_ok),
    .enable ((state == ST_RUN) && !halt),
    .count  (cycle_count),
    .limit  (wdog_hit)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_next = ST_PRERST;
      ST_PRERST:        if (rst_cnt == RST_LAST) state_next = ST_RUN;
      ST_RUN:           if (halt) state_next = NO_DUMP ? ST_DONE : ST_DUMP_REQ;
      ST_DUMP_REQ:      state_next = ST_DUMP_OUT;
      ST_DUMP_OUT:      if (dump_ready) state_next = is_last ? ST_DONE : ST_DUMP_REQ;
      default:          state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    proc_reset = (state != ST_RUN);
    mem_req    = (state == ST_DUMP_REQ);
    mem_addr   = '0;
    if (state == ST_DUMP_REQ) begin
      mem_addr = BASE_ADDR + (ADDR_W'(idx) << 2);
    end
    dump_valid = (state == ST_DUMP_OUT);
    dump_last  = (state == ST_DUMP_OUT) && is_last;
    done       = (state == ST_DONE);
    fsm_state  = state;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rst_cnt    <= '0;
      idx        <= '0;
      halt_cause <= HALT_NONE;
      dump_data  <= '0;
    end else begin
      if (start_ok) begin
        rst_cnt <= '0;
      end else if (state == ST_PRERST) begin
        rst_cnt <= rst_cnt + 32'd1;
      end

      if (start_ok) begin
        idx <= '0;
      end else if ((state == ST_DUMP_OUT) && dump_ready && !is_last) begin
        idx <= idx + 32'd1;
      end

      if (start_ok) begin
        halt_cause <= HALT_NONE;
      end else if (halt) begin
        halt_cause <= cause_sel;
      end

      // DMEM read data is combinational, so capture it in the request cycle.
      if (state == ST_DUMP_REQ) begin
        dump_data <= mem_rdata;
      end
    end
  end

  a_dump_hold: assert property (@(posedge clock) disable iff (reset)
    (dump_valid && !dump_ready) |=> (dump_valid && $stable(dump_data) && $stable(dump_last)));

endmodule

// File: tb/tb_proc_run_dump_ctrl.sv
// Randomized bench for proc_run_dump_ctrl: a 4-word dump instance and a
// zero-word instance, checked against a cycle-level reference of the run rules.
module tb_proc_run_dump_ctrl;

  localparam int          ADDR_W = 32;
  localparam int          DATA_W = 32;
  localparam int          BASE   = 8192;
  localparam int          N      = 4;
  localparam int          MAXC   = 50;
  localparam int          RC     = 2;
  localparam int          CNT_W  = 32;
  localparam logic [31:0] HALT   = 32'hFFFF_FFFF;

  logic              clock;
  logic              reset;
  logic              start;
  logic              start_z;
  logic [DATA_W-1:0] inst;
  logic              inst_valid;
  logic              dump_ready;

  logic              proc_reset, mem_req, dump_valid, dump_last, done;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata, dump_data;
  logic [1:0]        halt_cause;
  logic [CNT_W-1:0]  cycle_count;
  logic [2:0]        fsm_state;

  logic              proc_reset_z, mem_req_z, dump_valid_z, dump_last_z, done_z;
  logic [ADDR_W-1:0] mem_addr_z;
  logic [DATA_W-1:0] mem_rdata_z, dump_data_z;
  logic [1:0]        halt_cause_z;
  logic [CNT_W-1:0]  cycle_count_z;
  logic [2:0]        fsm_state_z;

  logic [31:0]       seed;
  logic [DATA_W-1:0] exp_q[$];
  int                checks;
  int                errors;

  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] s);
    return (a * 32'h9E37_79B1) ^ s ^ {a[15:0], a[31:16]};
  endfunction

  assign mem_rdata   = mem_word(mem_addr, seed);
  assign mem_rdata_z = mem_word(mem_addr_z, seed);

  proc_run_dump_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DUMP_BASE(BASE), .DUMP_WORDS(N),
    .HALT_INSTR(HALT), .MAX_CYCLES(MAXC), .RESET_CYCLES(RC), .CNT_W(CNT_W)
  ) u_dut (
    .clock(clock), .reset(reset), .start(start), .inst(inst), .inst_valid(inst_valid),
    .proc_reset(proc_reset), .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .dump_data(dump_data), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_last(dump_last), .done(done), .halt_cause(halt_cause),
    .cycle_count(cycle_count), .fsm_state(fsm_state)
  );

  proc_run_dump_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DUMP_BASE(BASE), .DUMP_WORDS(0),
    .HALT_INSTR(HALT), .MAX_CYCLES(MAXC), .RESET_CYCLES(RC), .CNT_W(CNT_W)
  ) u_dut_z (
    .clock(clock), .reset(reset), .start(start_z), .inst(inst), .inst_valid(inst_valid),
    .proc_reset(proc_reset_z), .mem_req(mem_req_z), .mem_addr(mem_addr_z),
    .mem_rdata(mem_rdata_z), .dump_data(dump_data_z), .dump_valid(dump_valid_z),
    .dump_ready(dump_ready), .dump_last(dump_last_z), .done(done_z),
    .halt_cause(halt_cause_z), .cycle_count(cycle_count_z), .fsm_state(fsm_state_z)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL global_timeout got no finish exp finish");
    $fatal(1, "bench timeout");
  end

  // Driver: random fetch for one RUN cycle; halt_now forces a valid HALT.
  task automatic drive_fetch(input bit halt_now);
    if (halt_now) begin
      inst_valid = 1'b1;
      inst       = HALT;
    end else begin
      inst_valid = 1'($urandom_range(0, 1));
      if (inst_valid) begin
        inst = $urandom();
        if (inst == HALT) inst = 32'h0000_0013;
      end else begin
        inst = ($urandom_range(0, 1) == 1) ? HALT : $urandom();
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (proc_reset !== 1'b1 || mem_req !== 1'b0 || mem_addr !== '0 || dump_valid !== 1'b0 ||
        dump_data !== '0 || dump_last !== 1'b0 || done !== 1'b0 || halt_cause !== 2'b00 ||
        cycle_count !== '0) begin
      errors++;
      $display("FAIL %s got pr=%b req=%b addr=%0h v=%b d=%0h l=%b done=%b hc=%b cc=%0d exp pr=1 rest 0",
               tag, proc_reset, mem_req, mem_addr, dump_valid, dump_data, dump_last, done,
               halt_cause, cycle_count);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; start_z = 1'b0; inst = '0; inst_valid = 1'b0; dump_ready = 1'b0;
    seed = $urandom();
    repeat (3) @(negedge clock);
    check_reset_values("reset_values");
    checks++;
    if (proc_reset_z !== 1'b1 || done_z !== 1'b0 || dump_valid_z !== 1'b0 || mem_req_z !== 1'b0) begin
      errors++;
      $display("FAIL reset_values_z got pr=%b done=%b v=%b req=%b exp 1 0 0 0",
               proc_reset_z, done_z, dump_valid_z, mem_req_z);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  // Full run on the 4-word instance. halt_at < 0 never issues a valid HALT.
  // ready_mode: 0 always ready, 1 random, 2 five stall cycles on the second word.
  task automatic run_check(input int halt_at, input int ready_mode, input bit poke_start);
    int c, halt_c, budget, k, stall;
    logic [1:0] cause;
    bit was_waiting;
    seed = $urandom();
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_q.push_back(mem_word(32'(BASE + 4 * i), seed));

    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    for (int r = 0; r < RC; r++) begin
      checks++;
      if (proc_reset !== 1'b1) begin
        errors++; $display("FAIL prerst_hold got %b exp 1 (cycle %0d)", proc_reset, r);
      end
      if (r == 0) begin
        checks++;
        if (cycle_count !== '0 || halt_cause !== 2'b00 || done !== 1'b0) begin
          errors++;
          $display("FAIL start_clear got cc=%0d hc=%b done=%b exp 0 00 0", cycle_count, halt_cause, done);
        end
      end
      @(negedge clock);
    end

    c = 0; cause = 2'b00;
    while (cause == 2'b00 && c < MAXC + 5) begin
      checks++;
      if (proc_reset !== 1'b0 || cycle_count !== 32'(c)) begin
        errors++;
        $display("FAIL run_cycle got pr=%b cc=%0d exp pr=0 cc=%0d", proc_reset, cycle_count, c);
      end
      drive_fetch(c == halt_at);
      start = poke_start && (c == 3);
      if (inst_valid && inst == HALT) cause = 2'b01;
      else if (c == MAXC - 1)         cause = 2'b11;
      @(negedge clock);
      c++;
    end
    start = 1'b0; inst_valid = 1'b0;
    halt_c = c - 1;

    checks++;
    if (halt_cause !== cause || cycle_count !== 32'(halt_c) || proc_reset !== 1'b1 || mem_req !== 1'b1) begin
      errors++;
      $display("FAIL halt_entry got hc=%b cc=%0d pr=%b req=%b exp hc=%b cc=%0d pr=1 req=1",
               halt_cause, cycle_count, proc_reset, mem_req, cause, halt_c);
    end

    k = 0; budget = 0; stall = 0; was_waiting = 1'b0;
    while (k < N && budget < 200) begin
      if (was_waiting && dump_valid !== 1'b1) begin
        checks++; errors++;
        $display("FAIL valid_dropped got v=%b req=%b exp v=1 (word %0d)", dump_valid, mem_req, k);
      end
      if (mem_req === 1'b1) begin
        checks++;
        if (mem_addr !== 32'(BASE + 4 * k) || dump_valid !== 1'b0) begin
          errors++;
          $display("FAIL dump_addr got addr=%0d v=%b exp addr=%0d v=0", mem_addr, dump_valid, BASE + 4 * k);
        end
        was_waiting = 1'b0;
      end else if (dump_valid === 1'b1) begin
        checks++;
        if (dump_data !== exp_q[k] || dump_last !== (k == N - 1)) begin
          errors++;
          $display("FAIL dump_word got d=%0h last=%b exp d=%0h last=%b (word %0d)",
                   dump_data, dump_last, exp_q[k], (k == N - 1), k);
        end
        case (ready_mode)
          0:       dump_ready = 1'b1;
          1:       dump_ready = 1'($urandom_range(0, 1));
          default: dump_ready = (k == 1 && stall < 5) ? 1'b0 : 1'b1;
        endcase
        if (!dump_ready) stall++;
        was_waiting = !dump_ready;
        if (dump_ready) k++;
      end else begin
        checks++; errors++;
        $display("FAIL dump_idle got req=0 v=0 exp req or valid (word %0d)", k);
      end
      @(negedge clock);
      budget++;
    end
    dump_ready = 1'b0;

    checks++;
    if (k != N) begin
      errors++; $display("FAIL dump_timeout got %0d words exp %0d", k, N);
    end
    checks++;
    if (done !== 1'b1 || dump_valid !== 1'b0 || halt_cause !== cause || cycle_count !== 32'(halt_c)) begin
      errors++;
      $display("FAIL done_state got done=%b v=%b hc=%b cc=%0d exp 1 0 %b %0d",
               done, dump_valid, halt_cause, cycle_count, cause, halt_c);
    end
    if (ready_mode == 0) begin
      checks++;
      if (budget != 2 * N) begin
        errors++; $display("FAIL throughput got %0d cycles exp %0d", budget, 2 * N);
      end
    end
    if (ready_mode == 2) begin
      checks++;
      if (stall != 5) begin
        errors++; $display("FAIL stall_count got %0d exp 5", stall);
      end
    end
  endtask

  task automatic test_halt_instr();
    run_check(20, 0, 1'b1);
  endtask

  task automatic test_watchdog();
    run_check(-1, 0, 1'b0);
  endtask

  task automatic test_halt_at_limit();
    run_check(MAXC - 1, 1, 1'b0);
  endtask

  task automatic test_stall();
    run_check($urandom_range(0, 30), 2, 1'b0);
  endtask

  task automatic test_random_runs();
    for (int i = 0; i < 5; i++) run_check($urandom_range(0, 60), 1, 1'($urandom_range(0, 1)));
  endtask

  task automatic test_zero_words();
    int h, c;
    bit seen_valid;
    h = $urandom_range(0, 30);
    seen_valid = 1'b0;
    @(negedge clock); start_z = 1'b1;
    @(negedge clock); start_z = 1'b0;
    repeat (RC) @(negedge clock);
    for (c = 0; c <= h; c++) begin
      if (dump_valid_z !== 1'b0) seen_valid = 1'b1;
      drive_fetch(c == h);
      @(negedge clock);
    end
    inst_valid = 1'b0;
    checks++;
    if (done_z !== 1'b1 || halt_cause_z !== 2'b01 || cycle_count_z !== 32'(h) ||
        mem_req_z !== 1'b0 || dump_valid_z !== 1'b0 || seen_valid) begin
      errors++;
      $display("FAIL zero_words got done=%b hc=%b cc=%0d req=%b v=%b seen=%b exp 1 01 %0d 0 0 0",
               done_z, halt_cause_z, cycle_count_z, mem_req_z, dump_valid_z, seen_valid, h);
    end
  endtask

  task automatic test_reset_mid_dump();
    int guard;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    guard = 0;
    while (proc_reset !== 1'b0 && guard < 20) begin @(negedge clock); guard++; end
    drive_fetch(1'b1);
    @(negedge clock);
    inst_valid = 1'b0;
    guard = 0;
    while (dump_valid !== 1'b1 && guard < 20) begin @(negedge clock); guard++; end
    checks++;
    if (dump_valid !== 1'b1) begin
      errors++; $display("FAIL reach_dump_out got v=%b exp 1", dump_valid);
    end
    #2 reset = 1'b1;
    #1 check_reset_values("async_reset");
    @(negedge clock);
    reset = 1'b0;
    run_check($urandom_range(0, 40), 1, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_halt_instr();
    test_watchdog();
    test_halt_at_limit();
    test_stall();
    test_zero_words();
    test_random_runs();
    test_reset_mid_dump();
    repeat (2) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
